// File: rtl/painterengine_gpu_pkg.sv
// Shared types and constants for the PainterEngine GPU DMA schedulers.
// Holds scheduler state encodings, error codes and channel indices.
package painterengine_gpu_pkg;

   typedef enum logic [1:0] {
      SCHED_IDLE        = 2'd0,
      SCHED_RESET_PULSE = 2'd1,
      SCHED_RUN         = 2'd2,
      SCHED_REPORT      = 2'd3
   } sched_state_t;

   localparam logic [2:0] ERR_OK      = 3'b000;
   localparam logic [2:0] ERR_TIMEOUT = 3'b111;

   localparam logic [1:0] CH_PIXEL   = 2'd0;
   localparam logic [1:0] CH_TEXTURE = 2'd1;
   localparam logic [1:0] CH_BLIT    = 2'd2;
   localparam logic [1:0] CH_CPU     = 2'd3;

   localparam int NUM_CH = 4;

   function automatic logic [3:0] onehot4(input logic [1:0] idx);
      return 4'b0001 << idx;
   endfunction

endpackage

// File: rtl/painterengine_gpu_rr_arbiter4.sv
// Combinational 4-way round-robin arbiter.
// Searches from pointer+1 (mod 4) for the first set request bit.
module painterengine_gpu_rr_arbiter4
   import painterengine_gpu_pkg::*;
(
   input  logic [3:0] request,
   input  logic [1:0] pointer,
   output logic       valid,
   output logic [1:0] index,
   output logic [3:0] onehot
);

   logic [1:0] cand;

   // scan the four candidates in rotating order, keep the first hit
   always_comb begin
      valid = 1'b0;
      index = 2'd0;
      cand  = 2'd0;
      for (int i = 1; i <= NUM_CH; i++) begin
         cand = pointer + 2'(i);
         if (!valid && request[cand]) begin
            valid = 1'b1;
            index = cand;
         end
      end
      onehot = valid ? onehot4(index) : 4'b0000;
   end

endmodule

// File: rtl/painterengine_gpu_writer_scheduler.sv
// Shares the single AXI DMA writer among pixel, texture, blit and CPU.
// Pulses the writer reset per job, supervises it and reports done/error.
module painterengine_gpu_writer_scheduler
   import painterengine_gpu_pkg::*;
#(
   parameter int          PARAM_RESET_CYCLES = 2,
   parameter logic [31:0] PARAM_TIMEOUT      = 32'd1048576
) (
   input  logic       i_wire_clock,
   input  logic       i_wire_resetn,
   input  logic [3:0] i_wire_request,
   output logic [3:0] o_wire_grant,
   output logic [3:0] o_wire_channel_done,
   output logic [3:0] o_wire_channel_error,
   output logic [2:0] o_wire_error_type,
   output logic       o_wire_busy,
   output logic       o_wire_writer_resetn,
   output logic [3:0] o_wire_writer_router,
   input  logic       i_wire_writer_done,
   input  logic       i_wire_writer_error,
   input  logic [2:0] i_wire_writer_error_type
);

   localparam logic [31:0] RST_LAST = 32'(PARAM_RESET_CYCLES - 1);
   localparam logic [31:0] TMO_LAST = PARAM_TIMEOUT - 32'd1;

   sched_state_t state;
   sched_state_t next_state;

   logic [1:0]  rr_pointer;
   logic [1:0]  rr_pointer_d;
   logic [31:0] counter;
   logic [31:0] counter_d;
   logic [3:0]  route;
   logic [3:0]  route_d;
   logic [3:0]  done;
   logic [3:0]  done_d;
   logic [3:0]  error;
   logic [3:0]  error_d;
   logic [2:0]  error_type;
   logic [2:0]  error_type_d;
   logic        busy;
   logic        busy_d;
   logic        writer_resetn;
   logic        writer_resetn_d;

   logic        arb_valid;
   logic [1:0]  arb_index;
   logic [3:0]  arb_onehot;
   logic [3:0]  winner;
   logic        reset_last;
   logic        timeout;

   painterengine_gpu_rr_arbiter4 u_arbiter (
      .request (i_wire_request),
      .pointer (rr_pointer),
      .valid   (arb_valid),
      .index   (arb_index),
      .onehot  (arb_onehot)
   );

   // rr_pointer holds the current job's channel for the whole job
   assign winner     = onehot4(rr_pointer);
   assign reset_last = (counter == RST_LAST);
   assign timeout    = (counter == TMO_LAST);

   // state register
   always_ff @(posedge i_wire_clock or negedge i_wire_resetn) begin
      if (!i_wire_resetn) begin
         state <= SCHED_IDLE;
      end else begin
         state <= next_state;
      end
   end

   // next-state decode; writer error outranks done, done outranks timeout
   always_comb begin
      next_state = state;
      case (state)
         SCHED_IDLE: begin
            if (arb_valid) next_state = SCHED_RESET_PULSE;
         end
         SCHED_RESET_PULSE: begin
            if (reset_last) next_state = SCHED_RUN;
         end
         SCHED_RUN: begin
            if (i_wire_writer_error || i_wire_writer_done || timeout)
               next_state = SCHED_REPORT;
         end
         SCHED_REPORT: begin
            next_state = SCHED_IDLE;
         end
         default: begin
            next_state = SCHED_IDLE;
         end
      endcase
   end

   // next values of all registered outputs and the job datapath
   always_comb begin
      rr_pointer_d    = rr_pointer;
      counter_d       = counter;
      route_d         = route;
      done_d          = 4'b0000;
      error_d         = 4'b0000;
      error_type_d    = error_type;
      writer_resetn_d = 1'b0;
      busy_d          = (next_state != SCHED_IDLE);
      case (state)
         SCHED_IDLE: begin
            if (arb_valid) begin
               route_d      = arb_onehot;
               rr_pointer_d = arb_index;
               counter_d    = 32'd0;
            end
         end
         SCHED_RESET_PULSE: begin
            if (reset_last) begin
               counter_d       = 32'd0;
               writer_resetn_d = 1'b1;
            end else begin
               counter_d = counter + 32'd1;
            end
         end
         SCHED_RUN: begin
            writer_resetn_d = 1'b1;
            counter_d       = timeout ? counter : counter + 32'd1;
            if (i_wire_writer_error) begin
               error_type_d = i_wire_writer_error_type;
               error_d      = winner;
            end else if (i_wire_writer_done) begin
               done_d = winner;
            end else if (timeout) begin
               error_type_d = ERR_TIMEOUT;
               error_d      = winner;
            end
         end
         SCHED_REPORT: begin
            route_d   = 4'b0000;
            counter_d = 32'd0;
         end
         default: begin
            route_d = 4'b0000;
         end
      endcase
   end

   // output and datapath registers; reset parks the writer in reset
   always_ff @(posedge i_wire_clock or negedge i_wire_resetn) begin
      if (!i_wire_resetn) begin
         rr_pointer    <= CH_CPU;
         counter       <= 32'd0;
         route         <= 4'b0000;
         done          <= 4'b0000;
         error         <= 4'b0000;
         error_type    <= ERR_OK;
         busy          <= 1'b0;
         writer_resetn <= 1'b0;
      end else begin
         rr_pointer    <= rr_pointer_d;
         counter       <= counter_d;
         route         <= route_d;
         done          <= done_d;
         error         <= error_d;
         error_type    <= error_type_d;
         busy          <= busy_d;
         writer_resetn <= writer_resetn_d;
      end
   end

   assign o_wire_grant         = route;
   assign o_wire_writer_router = route;
   assign o_wire_channel_done  = done;
   assign o_wire_channel_error = error;
   assign o_wire_error_type    = error_type;
   assign o_wire_busy          = busy;
   assign o_wire_writer_resetn = writer_resetn;

endmodule

// File: tb/tb_painterengine_gpu_writer_scheduler.sv
// Self-checking bench for the writer scheduler.
// Directed vector table plus hand-written multi-cycle sequences.
module tb_painterengine_gpu_writer_scheduler;

   logic       clk;
   logic       rst_n;
   logic [3:0] req;
   logic [3:0] grant;
   logic [3:0] done;
   logic [3:0] err;
   logic [2:0] etype;
   logic       busy;
   logic       wrn;
   logic [3:0] router;
   logic       wd;
   logic       we;
   logic [2:0] wet;

   int nvec;
   int nerr;

   typedef struct {
      logic [3:0] req;
      logic       wd;
      logic       we;
      logic [2:0] wet;
      logic [3:0] eg;
      logic [3:0] ed;
      logic [3:0] ee;
      logic [2:0] eet;
      logic       eb;
      logic       ewr;
      logic       cwr;
   } vec_t;

   vec_t vt[$];

   painterengine_gpu_writer_scheduler #(
      .PARAM_RESET_CYCLES (2),
      .PARAM_TIMEOUT      (32'd64)
   ) dut (
      .i_wire_clock             (clk),
      .i_wire_resetn            (rst_n),
      .i_wire_request           (req),
      .o_wire_grant             (grant),
      .o_wire_channel_done      (done),
      .o_wire_channel_error     (err),
      .o_wire_error_type        (etype),
      .o_wire_busy              (busy),
      .o_wire_writer_resetn     (wrn),
      .o_wire_writer_router     (router),
      .i_wire_writer_done       (wd),
      .i_wire_writer_error      (we),
      .i_wire_writer_error_type (wet)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic addv(input logic [3:0] r, input logic d, input logic e,
                       input logic [2:0] t, input logic [3:0] g,
                       input logic [3:0] xd, input logic [3:0] xe,
                       input logic [2:0] xt, input logic b,
                       input logic w, input logic cw);
      vec_t v;
      v.req = r; v.wd = d; v.we = e; v.wet = t;
      v.eg = g; v.ed = xd; v.ee = xe; v.eet = xt;
      v.eb = b; v.ewr = w; v.cwr = cw;
      vt.push_back(v);
   endtask

   task automatic wait_run(input string nm);
      int n;
      n = 0;
      while (!wrn && n < 10) begin
         step();
         n++;
      end
      chk(nm, {31'd0, wrn}, 32'd1);
   endtask

   initial begin
      int n;
      logic [3:0] exp;
      nvec = 0;
      nerr = 0;
      rst_n = 1'b0;
      req = 4'b0;
      wd = 1'b0;
      we = 1'b0;
      wet = 3'b0;

      // job on channel 2, done after a run phase
      addv(4'b0100, 0, 0, 3'b000, 4'b0100, 4'b0, 4'b0, 3'b000, 1, 0, 1);
      addv(4'b0100, 0, 0, 3'b000, 4'b0100, 4'b0, 4'b0, 3'b000, 1, 0, 1);
      addv(4'b0100, 0, 0, 3'b000, 4'b0100, 4'b0, 4'b0, 3'b000, 1, 1, 1);
      for (int k = 0; k < 9; k++)
         addv(4'b0100, 0, 0, 3'b000, 4'b0100, 4'b0, 4'b0, 3'b000, 1, 1, 1);
      addv(4'b0100, 1, 0, 3'b000, 4'b0100, 4'b0100, 4'b0, 3'b000, 1, 0, 0);
      addv(4'b0000, 0, 0, 3'b000, 4'b0000, 4'b0, 4'b0, 3'b000, 0, 0, 1);
      // channel 1, writer error code 3
      addv(4'b0010, 0, 0, 3'b000, 4'b0010, 4'b0, 4'b0, 3'b000, 1, 0, 1);
      addv(4'b0010, 0, 0, 3'b000, 4'b0010, 4'b0, 4'b0, 3'b000, 1, 0, 1);
      addv(4'b0000, 0, 0, 3'b000, 4'b0010, 4'b0, 4'b0, 3'b000, 1, 1, 1);
      addv(4'b0000, 0, 1, 3'b011, 4'b0010, 4'b0, 4'b0010, 3'b011, 1, 0, 0);
      addv(4'b0000, 0, 0, 3'b000, 4'b0000, 4'b0, 4'b0, 3'b011, 0, 0, 1);
      addv(4'b0000, 0, 0, 3'b000, 4'b0000, 4'b0, 4'b0, 3'b011, 0, 0, 1);
      // channel 3, done and error together: error wins
      addv(4'b1000, 0, 0, 3'b000, 4'b1000, 4'b0, 4'b0, 3'b011, 1, 0, 1);
      addv(4'b0000, 0, 0, 3'b000, 4'b1000, 4'b0, 4'b0, 3'b011, 1, 0, 1);
      addv(4'b0000, 0, 0, 3'b000, 4'b1000, 4'b0, 4'b0, 3'b011, 1, 1, 1);
      addv(4'b0000, 1, 1, 3'b101, 4'b1000, 4'b0, 4'b1000, 3'b101, 1, 0, 0);
      addv(4'b0000, 0, 0, 3'b000, 4'b0000, 4'b0, 4'b0, 3'b101, 0, 0, 1);

      repeat (3) @(posedge clk);
      #1;
      chk("reset grant", {28'd0, grant}, 32'd0);
      chk("reset router", {28'd0, router}, 32'd0);
      chk("reset wrn", {31'd0, wrn}, 32'd0);
      chk("reset busy", {31'd0, busy}, 32'd0);
      chk("reset etype", {29'd0, etype}, 32'd0);
      rst_n = 1'b1;
      step();

      foreach (vt[i]) begin
         req = vt[i].req;
         wd  = vt[i].wd;
         we  = vt[i].we;
         wet = vt[i].wet;
         step();
         chk($sformatf("v%0d grant", i), {28'd0, grant}, {28'd0, vt[i].eg});
         chk($sformatf("v%0d router", i), {28'd0, router}, {28'd0, vt[i].eg});
         chk($sformatf("v%0d done", i), {28'd0, done}, {28'd0, vt[i].ed});
         chk($sformatf("v%0d error", i), {28'd0, err}, {28'd0, vt[i].ee});
         chk($sformatf("v%0d etype", i), {29'd0, etype}, {29'd0, vt[i].eet});
         chk($sformatf("v%0d busy", i), {31'd0, busy}, {31'd0, vt[i].eb});
         if (vt[i].cwr)
            chk($sformatf("v%0d wrn", i), {31'd0, wrn}, {31'd0, vt[i].ewr});
      end
      req = 4'b0;
      wd  = 1'b0;
      we  = 1'b0;
      wet = 3'b0;

      // all four held: round-robin order 0,1,2,3,0
      req = 4'b1111;
      for (int k = 0; k < 5; k++) begin
         exp = 4'b0001 << (k % 4);
         n = 0;
         while (grant == 4'b0 && n < 10) begin
            step();
            n++;
         end
         chk($sformatf("rr%0d grant", k), {28'd0, grant}, {28'd0, exp});
         wait_run($sformatf("rr%0d run", k));
         wd = 1'b1;
         step();
         chk($sformatf("rr%0d done", k), {28'd0, done}, {28'd0, exp});
         wd = 1'b0;
         if (k == 4) req = 4'b0;
         step();
         chk($sformatf("rr%0d idle", k), {28'd0, grant}, 32'd0);
      end
      step();

      // silent writer: timeout 64 cycles after entering run
      req = 4'b0001;
      step();
      req = 4'b0;
      chk("tmo grant", {28'd0, grant}, 32'h1);
      wait_run("tmo run");
      n = 0;
      while (err == 4'b0 && n < 100) begin
         step();
         n++;
      end
      chk("tmo cycles", n, 32'd64);
      chk("tmo error", {28'd0, err}, 32'h1);
      chk("tmo done", {28'd0, done}, 32'd0);
      chk("tmo etype", {29'd0, etype}, 32'h7);
      step();
      chk("tmo wrn", {31'd0, wrn}, 32'd0);
      chk("tmo busy", {31'd0, busy}, 32'd0);
      chk("tmo clear", {28'd0, err}, 32'd0);

      // asynchronous reset in the middle of a job
      req = 4'b0010;
      step();
      req = 4'b0;
      chk("ar grant", {28'd0, grant}, 32'h2);
      wait_run("ar run");
      repeat (3) step();
      #2;
      rst_n = 1'b0;
      #1;
      chk("ar grant0", {28'd0, grant}, 32'd0);
      chk("ar router0", {28'd0, router}, 32'd0);
      chk("ar wrn0", {31'd0, wrn}, 32'd0);
      chk("ar busy0", {31'd0, busy}, 32'd0);
      chk("ar etype0", {29'd0, etype}, 32'd0);
      repeat (2) step();
      chk("ar pulse", {24'd0, done, err}, 32'd0);
      rst_n = 1'b1;
      req = 4'b1111;
      step();
      req = 4'b0;
      chk("ar next grant", {28'd0, grant}, 32'h1);
      for (int k = 0; k < 3; k++) begin
         step();
         chk($sformatf("ar quiet%0d", k), {24'd0, done, err}, 32'd0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
